// File: rtl/game_io_mmio.sv
// Memory-mapped game I/O block: debounced buttons feeding a press-event FIFO,
// latched/timed-flash LEDs and a reseedable 32-bit Galois LFSR in a 4-word window.
module game_io_mmio #(
    parameter int          NUM_CH          = 4,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          FLASH_CYCLES    = 12500000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [11:0] BASE_ADDR       = 12'd5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic [11:0]       address_dmem,
    input  logic [31:0]       data,
    output logic [31:0]       q_mmio,
    output logic              hit,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] leds
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int FL_W  = $clog2(FLASH_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0]      LFSR_SEED = 32'hACE10001;
    localparam logic [31:0]      LFSR_TAPS = 32'h80200003;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FL_W-1:0]  FL_LOAD   = FL_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] FIFO_CAP  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_RAND   = 2'd0,
        REG_LED    = 2'd1,
        REG_PRESS  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [11:0] offset;
    reg_e        reg_sel;
    logic        wr_rand, wr_led, wr_press, wr_status;

    assign offset    = address_dmem - BASE_ADDR;
    assign hit       = (offset < 12'd4);
    assign reg_sel   = reg_e'(offset[1:0]);
    assign wr_rand   = wren && hit && (reg_sel == REG_RAND);
    assign wr_led    = wren && hit && (reg_sel == REG_LED);
    assign wr_press  = wren && hit && (reg_sel == REG_PRESS);
    assign wr_status = wren && hit && (reg_sel == REG_STATUS);

    // ------------------------------------------------------------------
    // LFSR: right-shifting Galois form, never reaches the all-zero state
    // ------------------------------------------------------------------
    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        if (wr_rand) begin
            lfsr_d = (data == 32'd0) ? LFSR_SEED : data;
        end else begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    // ------------------------------------------------------------------
    // Button synchronizers, debouncers and rising-edge pending bits
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] deb_q, deb_d, deb_prev_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] rise, grant_oh;
    logic [DB_W-1:0]   db_cnt_q [NUM_CH];
    logic [DB_W-1:0]   db_cnt_d [NUM_CH];
    logic [3:0]        grant_idx;
    logic              push_req;

    // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = 4'(i);
            end
        end
    end

    assign push_req  = |pending_q;
    assign pending_d = (pending_q & ~grant_oh) | rise;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            pending_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= buttons;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pending_q  <= pending_d;
            for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // ------------------------------------------------------------------
    // Press-event FIFO; a pop frees a slot for a same-cycle push even when full
    // ------------------------------------------------------------------
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, fifo_empty, pop, push, drop;

    assign fifo_full  = (count_q == FIFO_CAP);
    assign fifo_empty = (count_q == '0);
    assign pop        = wr_press && !fifo_empty;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign ovf_d      = (ovf_q && !wr_status) || drop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= grant_idx;
    end

    // ------------------------------------------------------------------
    // LEDs: latched or timed flash; the flash counter turns the LED off at 0
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] led_q, led_d;
    logic [FL_W-1:0]   fcnt_q [NUM_CH];
    logic [FL_W-1:0]   fcnt_d [NUM_CH];
    logic              led_on, led_flash, led_bcast;
    logic [3:0]        led_ch;

    assign led_ch    = data[3:0];
    assign led_on    = data[8];
    assign led_flash = data[9];
    assign led_bcast = data[10];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            led_d[i]  = led_q[i];
            fcnt_d[i] = fcnt_q[i];
            if (wr_led && (led_bcast || (led_ch == 4'(i)))) begin
                led_d[i]  = led_on;
                fcnt_d[i] = (led_on && led_flash) ? FL_LOAD : '0;
            end else if (fcnt_q[i] != '0) begin
                fcnt_d[i] = fcnt_q[i] - FL_W'(1);
                if (fcnt_q[i] == FL_W'(1)) led_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= '0;
            for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= '0;
        end else begin
            led_q <= led_d;
            for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    assign leds = led_q;

    // ------------------------------------------------------------------
    // Zero-latency read mux
    // ------------------------------------------------------------------
    always_comb begin
        q_mmio = '0;
        if (hit) begin
            case (reg_sel)
                REG_RAND:   q_mmio = lfsr_q;
                REG_LED:    q_mmio = '0;
                REG_PRESS:  q_mmio = fifo_empty ? 32'd0 : {1'b1, 27'd0, fifo_mem[rd_ptr_q]};
                REG_STATUS: q_mmio = {ovf_q, 23'd0, 8'(count_q)};
                default:    q_mmio = '0;
            endcase
        end
    end

endmodule
